// File: rtl/adc_channel_sequencer.sv
// Round-robin conversion scheduler for the SPI ADC capture block: picks the next enabled
// channel, issues one conversion, checks the echoed address and streams the 12-bit result.
module adc_channel_sequencer #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [15:0]       gap_cycles,
  output logic              conv_start,
  output logic [2:0]        conv_addr,
  input  logic              conv_done,
  input  logic [15:0]       conv_frame,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2:0]        res_chan,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              scan_done,
  output logic              timeout
);

  localparam int unsigned CH_W  = 3;
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 16) ? $clog2(TIMEOUT_CYC) : 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StPick, StStart, StWait, StEmit, StGap} state_e;

  state_e            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              pick_found;
  logic [CH_W-1:0]   pick_idx;
  logic              hi_found;
  logic [CH_W-1:0]   hi_idx;

  // Walk the search order backwards so the last hit is the first channel after ptr_q.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (ch_enable[CH_W'((int'(ptr_q) + i) % NUM_CH)]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'((int'(ptr_q) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_enable[CH_W'(i)]) begin
        hi_found = 1'b1;
        hi_idx   = CH_W'(i);
      end
    end
  end

  // End-of-scan marks the accepted result of the highest channel currently enabled.
  assign scan_done = res_valid && res_ready && hi_found && (res_chan == hi_idx);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= CH_W'(NUM_CH - 1);
      cnt_q      <= '0;
      conv_start <= 1'b0;
      conv_addr  <= '0;
      res_valid  <= 1'b0;
      res_chan   <= '0;
      res_data   <= '0;
      res_err    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      case (state_q)
        StIdle: begin
          if (run && |ch_enable) state_q <= StPick;
        end
        StPick: begin
          if (pick_found) begin
            conv_addr  <= pick_idx;
            ptr_q      <= pick_idx;
            conv_start <= 1'b1;
            state_q    <= StStart;
          end else begin
            state_q <= StIdle;
          end
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (conv_done) begin
            res_data  <= conv_frame[DATA_W-1:0];
            res_chan  <= conv_addr;
            res_err   <= conv_frame[15] | (conv_frame[14:12] != conv_addr);
            res_valid <= 1'b1;
            state_q   <= StEmit;
          end else if (cnt_q == TO_LAST) begin
            timeout <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StEmit: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (gap_cycles == 16'd0) begin
              state_q <= StIdle;
            end else begin
              // Counter holds remaining gap cycles minus one.
              cnt_q   <= CNT_W'(gap_cycles - 16'd1);
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (cnt_q == '0) state_q <= StIdle;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Bench for adc_channel_sequencer: directed vector table, hand-written corner sequences and a
// randomized run scored against a channel-order / frame-decode model of the capture path.
module tb_adc_channel_sequencer;

  logic        CLOCK_50;
  logic        reset, run, conv_start, conv_done, res_valid, res_ready, res_err;
  logic        scan_done, timeout;
  logic [7:0]  ch_enable;
  logic [15:0] gap_cycles, conv_frame;
  logic [2:0]  conv_addr, res_chan;
  logic [11:0] res_data;

  adc_channel_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .run        (run),
    .ch_enable  (ch_enable),
    .gap_cycles (gap_cycles),
    .conv_start (conv_start),
    .conv_addr  (conv_addr),
    .conv_done  (conv_done),
    .conv_frame (conv_frame),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_chan   (res_chan),
    .res_data   (res_data),
    .res_err    (res_err),
    .scan_done  (scan_done),
    .timeout    (timeout)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  typedef struct {
    logic [2:0]  chan;
    logic [11:0] data;
    logic        err;
  } res_t;

  typedef struct {
    logic [7:0]  en;
    logic [15:0] frame;
    logic [2:0]  chan;
    logic [11:0] data;
    logic        err;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  bit          resp_en = 1'b1;
  int          resp_delay = 2;
  bit          frame_override_en = 1'b0;
  logic [15:0] frame_override = 16'h0;
  bit          bad_frames = 1'b0;
  int          manual_req = 0;
  int          manual_seen = 0;
  logic [15:0] manual_frame = 16'h0;
  int          n_starts = 0;
  int          n_results = 0;
  logic [2:0]  start_log[$];
  res_t        exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Next channel in round-robin order after ptr, straight from the scheduling rule.
  function automatic logic [2:0] model_next(input logic [7:0] en, input logic [2:0] ptr);
    int c;
    for (int k = 1; k <= 8; k++) begin
      c = (int'(ptr) + k) % 8;
      if (en[c[2:0]]) return c[2:0];
    end
    return 3'd0;
  endfunction

  function automatic int model_highest(input logic [7:0] en);
    for (int k = 7; k >= 0; k--) if (en[k]) return k;
    return -1;
  endfunction

  // Capture-block model plus scoreboard: samples on negedge, drives conv_done after posedge.
  logic [2:0]  model_ptr = 3'd7;
  logic [7:0]  prev_en = 8'h0;
  int          countdown = -1;
  logic [15:0] pend_frame = 16'h0;
  logic [15:0] f;
  logic [2:0]  exp_addr;
  res_t        e;

  initial begin
    conv_done  = 1'b0;
    conv_frame = 16'h0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        exp_q.delete();
        countdown = -1;
        model_ptr = 3'd7;
      end else begin
        if (conv_start) begin
          n_starts++;
          exp_addr = model_next(prev_en, model_ptr);
          check("pick_addr", conv_addr, exp_addr);
          model_ptr = exp_addr;
          start_log.push_back(conv_addr);
          if (resp_en) begin
            if (frame_override_en) f = frame_override;
            else if (bad_frames && $urandom_range(0, 4) == 0) f = 16'($urandom);
            else f = {1'b0, conv_addr, 12'($urandom)};
            pend_frame = f;
            countdown  = resp_delay - 1;
            e.chan = exp_addr;
            e.data = f[11:0];
            e.err  = f[15] | (f[14:12] != conv_addr);
            exp_q.push_back(e);
          end
        end
        if (res_valid && res_ready) begin
          n_results++;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("res_chan", res_chan, e.chan);
            check("res_data", res_data, e.data);
            check("res_err", res_err, e.err);
            check("scan_done", scan_done,
                  (model_highest(ch_enable) == int'(e.chan)) ? 1 : 0);
          end
        end else begin
          check("scan_idle", scan_done, 0);
        end
      end
      prev_en = ch_enable;
      @(posedge CLOCK_50);
      #1;
      conv_done = 1'b0;
      if (countdown == 0) begin
        conv_done  = 1'b1;
        conv_frame = pend_frame;
        countdown  = -1;
      end else if (countdown > 0) begin
        countdown--;
      end
      if (manual_req != manual_seen) begin
        conv_done  = 1'b1;
        conv_frame = manual_frame;
        manual_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // cyc = index of the negedge (0 = first one) at which the event was seen.
  task automatic wait_start(input string tag, output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge CLOCK_50);
      if (conv_start) break;
      cyc++;
    end
    if (cyc >= 2000) check({tag, "_start_bound"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge CLOCK_50);
      if (res_valid) break;
      cyc++;
    end
    if (cyc >= 2000) check({tag, "_valid_bound"}, 0, 1);
  endtask

  vec_t       vecs[6];
  logic [2:0] t1_exp[4];
  int         cyc, base, s0, r0, j;

  initial begin
    vecs[0] = '{8'h80, 16'h7F8C, 3'd7, 12'hF8C, 1'b0};
    vecs[1] = '{8'h80, 16'h3F8C, 3'd7, 12'hF8C, 1'b1};
    vecs[2] = '{8'h01, 16'h0123, 3'd0, 12'h123, 1'b0};
    vecs[3] = '{8'h0C, 16'h2ABC, 3'd2, 12'hABC, 1'b0};
    vecs[4] = '{8'h0C, 16'hA555, 3'd2, 12'h555, 1'b1};
    vecs[5] = '{8'h40, 16'h6FFF, 3'd6, 12'hFFF, 1'b0};
    t1_exp[0] = 3'd0; t1_exp[1] = 3'd4; t1_exp[2] = 3'd0; t1_exp[3] = 3'd4;

    reset = 1'b1; run = 1'b0; ch_enable = 8'h0; gap_cycles = 16'd0; res_ready = 1'b1;

    // Reset state and alternating two-channel scan
    do_reset();
    @(negedge CLOCK_50);
    check("reset_outputs", {conv_start, conv_addr, res_valid, res_chan, res_data, res_err,
                            scan_done, timeout}, 0);
    tick();
    ch_enable = 8'h11;
    base = start_log.size();
    run = 1'b1;
    wait_start("t1", cyc);
    check("run_to_start_latency", cyc, 2);
    for (int i = 0; i < 400 && start_log.size() < base + 4; i++) tick();
    run = 1'b0;
    check("t1_start_count", (start_log.size() >= base + 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++)
      if (start_log.size() > base + i) check("t1_order", start_log[base + i], t1_exp[i]);
    repeat (30) tick();
    check("t1_drain", exp_q.size(), 0);

    // Directed frame vectors
    frame_override_en = 1'b1;
    resp_delay = 3;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      ch_enable = vecs[v].en;
      frame_override = vecs[v].frame;
      run = 1'b1;
      wait_start("vec", cyc);
      wait_valid("vec", cyc);
      run = 1'b0;
      check("vec_done_to_valid", cyc, resp_delay);
      check("vec_chan", res_chan, vecs[v].chan);
      check("vec_data", res_data, vecs[v].data);
      check("vec_err", res_err, vecs[v].err);
      repeat (5) tick();
    end

    // Back-pressure hold, then an exact 10-cycle gap
    do_reset();
    ch_enable = 8'h20;
    frame_override = 16'h5ABC;
    gap_cycles = 16'd10;
    res_ready = 1'b0;
    run = 1'b1;
    wait_valid("t3", cyc);
    s0 = n_starts;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      check("hold_stable", {res_valid, res_chan, res_data, res_err},
            {1'b1, 3'd5, 12'hABC, 1'b0});
    end
    check("hold_no_start", n_starts, s0);
    tick();
    res_ready = 1'b1;
    @(posedge CLOCK_50);
    j = 0;
    while (j < 60) begin
      @(negedge CLOCK_50);
      if (j == 0) check("valid_drop", res_valid, 0);
      if (conv_start) break;
      j++;
    end
    // GAP holds 10 cycles, then IDLE and PICK precede the next start
    check("gap_to_start", j, 12);
    run = 1'b0;
    frame_override_en = 1'b0;
    gap_cycles = 16'd0;
    repeat (40) tick();

    // Timeout with no conv_done; next pick moves on
    do_reset();
    ch_enable = 8'h05;
    resp_en = 1'b0;
    resp_delay = 2;
    r0 = n_results;
    run = 1'b1;
    wait_start("t4", cyc);
    j = 0;
    while (j < 1100 && !timeout) begin
      @(negedge CLOCK_50);
      j++;
    end
    check("timeout_cycles", j, 1025);
    check("timeout_no_result", n_results, r0);
    resp_en = 1'b1;
    wait_start("t4b", cyc);
    check("timeout_to_restart", cyc, 1);
    check("after_timeout_addr", conv_addr, 3'd2);
    run = 1'b0;
    wait_valid("t4", cyc);
    repeat (5) tick();
    check("timeout_sticky", timeout, 1);
    check("t4_results", n_results - r0, 1);

    // Reset during WAIT, stray conv_done during reset and in IDLE
    do_reset();
    check("reset_clears_timeout", timeout, 0);
    ch_enable = 8'h0A;
    resp_en = 1'b0;
    run = 1'b1;
    wait_start("t5", cyc);
    check("t5_first_addr", conv_addr, 3'd1);
    repeat (3) tick();
    reset = 1'b1;
    manual_frame = 16'h1123;
    manual_req++;
    tick();
    tick();
    @(negedge CLOCK_50);
    check("reset_mid_wait", {conv_start, conv_addr, res_valid, res_chan, res_data, res_err,
                             scan_done, timeout}, 0);
    tick();
    reset = 1'b0;
    run = 1'b0;
    r0 = n_results;
    repeat (3) tick();
    manual_frame = 16'h1456;
    manual_req++;
    repeat (6) tick();
    check("done_outside_wait", n_results, r0);
    check("no_valid_idle", res_valid, 0);
    resp_en = 1'b1;
    run = 1'b1;
    wait_start("t5b", cyc);
    check("post_reset_first_addr", conv_addr, 3'd1);
    run = 1'b0;
    repeat (20) tick();

    // run dropped mid-conversion; empty enable mask with run high
    do_reset();
    ch_enable = 8'h03;
    resp_delay = 5;
    run = 1'b1;
    wait_start("t6", cyc);
    tick();
    s0 = n_starts;
    r0 = n_results;
    run = 1'b0;
    wait_valid("t6", cyc);
    repeat (30) tick();
    check("t6_result_emitted", n_results - r0, 1);
    check("t6_no_restart", n_starts, s0);
    ch_enable = 8'h00;
    run = 1'b1;
    repeat (20) tick();
    check("empty_mask_idle", n_starts, s0);
    run = 1'b0;

    // Randomized traffic against the model
    do_reset();
    bad_frames = 1'b1;
    ch_enable = 8'h5B;
    r0 = n_results;
    run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 40) == 0)
        ch_enable = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 60) == 0) run = ~run;
      res_ready  = ($urandom_range(0, 3) != 0);
      gap_cycles = 16'($urandom_range(0, 3));
      resp_delay = $urandom_range(1, 6);
    end
    run = 1'b0;
    res_ready = 1'b1;
    repeat (60) tick();
    check("rand_drain", exp_q.size(), 0);
    check("rand_progress", (n_results > r0 + 20) ? 1 : 0, 1);
    bad_frames = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
